// File: rtl/inst_cache_pkg.sv
// +-----------------------------------------------------------------------------+
// | inst_cache_pkg: shared encodings and helpers for the instruction cache.     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package inst_cache_pkg;

  localparam logic c_high = 1'b1;
  localparam logic c_low  = 1'b0;

  localparam int c_icache_index_bits = 8;

  typedef enum logic [0:0] {
    ICACHE_IDLE = 1'b0,
    ICACHE_MISS = 1'b1
  } icache_state_t;

  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_array.sv
// +-----------------------------------------------------------------------------+
// | icache_array: valid/tag/data storage, combinational read, synchronous write.|
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module icache_array #(
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]         r_data [LINES];

  // Only the valid bits are cleared; stale tag/data are harmless behind valid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (we) begin
      r_valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      r_tag[wr_index]  <= wr_tag;
      r_data[wr_index] <= wr_data;
    end
  end

  assign rd_valid = r_valid[rd_index];
  assign rd_tag   = r_tag[rd_index];
  assign rd_data  = r_data[rd_index];

endmodule

`default_nettype wire

// File: rtl/inst_cache.sv
// +-----------------------------------------------------------------------------+
// | inst_cache: direct-mapped one-word-line instruction cache; ICACHE_STATS_EN  |
// | adds saturating hit/miss counters. Rev 1.0                                  |
// +-----------------------------------------------------------------------------+
`default_nettype none

module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS = c_icache_index_bits
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        if_flush,
  output logic        if_ready,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic        mc_valid,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_inst
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  icache_state_t         r_state, w_state_nxt;
  logic [INDEX_BITS-1:0] r_idx, w_idx_nxt;
  logic [TAG_BITS-1:0]   r_tag, w_tag_nxt;
  logic                  r_flush_pend, w_flush_pend_nxt;
  logic                  r_inst_valid, w_inst_valid_nxt;
  logic [31:0]           r_inst_out, w_inst_out_nxt;
  logic                  r_mc_valid, w_mc_valid_nxt;
  logic [31:0]           r_mc_addr, w_mc_addr_nxt;

  logic [INDEX_BITS-1:0] w_req_index;
  logic [TAG_BITS-1:0]   w_req_tag;
  logic                  w_rd_valid;
  logic [TAG_BITS-1:0]   w_rd_tag;
  logic [31:0]           w_rd_data;
  logic                  w_lookup_hit;
  logic                  w_fill;
  logic                  w_unused_pc_bits;

  assign w_req_index      = if_pc[INDEX_BITS+1:2];
  assign w_req_tag        = if_pc[31:INDEX_BITS+2];
  assign w_unused_pc_bits = &{1'b0, if_pc[1:0]};
  assign w_lookup_hit     = w_rd_valid && (w_rd_tag == w_req_tag);

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (w_req_index),
    .rd_valid (w_rd_valid),
    .rd_tag   (w_rd_tag),
    .rd_data  (w_rd_data),
    .we       (w_fill && rdy),
    .wr_index (r_idx),
    .wr_tag   (r_tag),
    .wr_data  (mc_inst)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_tag_nxt        = r_tag;
    w_flush_pend_nxt = r_flush_pend;
    w_inst_valid_nxt = c_low;
    w_inst_out_nxt   = r_inst_out;
    w_mc_valid_nxt   = r_mc_valid;
    w_mc_addr_nxt    = r_mc_addr;
    w_fill           = c_low;
    case (r_state)
      ICACHE_IDLE: begin
        if (if_valid && !if_flush) begin
          if (w_lookup_hit) begin
            w_inst_valid_nxt = c_high;
            w_inst_out_nxt   = w_rd_data;
          end else begin
            w_mc_valid_nxt = c_high;
            w_mc_addr_nxt  = word_addr(if_pc);
            w_idx_nxt      = w_req_index;
            w_tag_nxt      = w_req_tag;
            w_state_nxt    = ICACHE_MISS;
          end
        end
      end
      ICACHE_MISS: begin
        // A flush never aborts the fetch; it only suppresses the eventual answer.
        if (mc_done) begin
          w_fill           = c_high;
          w_mc_valid_nxt   = c_low;
          w_inst_valid_nxt = ~(r_flush_pend | if_flush);
          w_inst_out_nxt   = mc_inst;
          w_flush_pend_nxt = c_low;
          w_state_nxt      = ICACHE_IDLE;
        end else if (if_flush) begin
          w_flush_pend_nxt = c_high;
        end
      end
      default: begin
        w_state_nxt = ICACHE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ICACHE_IDLE;
      r_idx        <= '0;
      r_tag        <= '0;
      r_flush_pend <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst_out   <= '0;
      r_mc_valid   <= 1'b0;
      r_mc_addr    <= '0;
    end else if (rdy) begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_tag        <= w_tag_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_inst_out   <= w_inst_out_nxt;
      r_mc_valid   <= w_mc_valid_nxt;
      r_mc_addr    <= w_mc_addr_nxt;
    end
  end

  assign if_ready   = (r_state == ICACHE_IDLE);
  assign inst_valid = r_inst_valid;
  assign inst_out   = r_inst_out;
  assign mc_valid   = r_mc_valid;
  assign mc_addr    = r_mc_addr;

`ifdef ICACHE_STATS_EN
  logic        w_hit, w_miss;
  logic [31:0] r_hit_cnt, r_miss_cnt;

  assign w_hit  = (r_state == ICACHE_IDLE) && if_valid && !if_flush && w_lookup_hit;
  assign w_miss = (r_state == ICACHE_IDLE) && if_valid && !if_flush && !w_lookup_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (rdy) begin
      if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

`default_nettype wire
